// File: rtl/key_time_entry_pkg.sv
// Shared constants and types for the keypad time-entry block.
package key_pkg;

   localparam logic [3:0] KEY_START  = 4'd10;
   localparam logic [3:0] KEY_BKSP   = 4'd11;
   localparam logic [3:0] KEY_CANCEL = 4'd12;
   localparam logic [3:0] KEY_COMMIT = 4'd13;
   localparam logic [3:0] BCD_BLANK  = 4'hF;

   localparam logic [23:0] DIGITS_BLANK = {6{BCD_BLANK}};

   typedef enum logic [2:0] {
      ST_IDLE  = 3'b001,
      ST_ENTRY = 3'b010,
      ST_CHECK = 3'b100
   } state_t;

   function automatic logic is_digit(input logic [3:0] k);
      return k <= 4'd9;
   endfunction

endpackage

// File: rtl/key_time_entry_if.sv
// Key strobe input plus entry/readout signals between keypad scanner, entry block and clock core.
interface key_time_entry_if;
   logic [3:0]  KEY_Value;
   logic        Value_en;
   logic        ENTRY_ACTIVE;
   logic [23:0] ENTRY_DIGITS;
   logic [2:0]  DIGIT_CNT;
   logic [4:0]  SET_HOUR;
   logic [5:0]  SET_MIN;
   logic [5:0]  SET_SEC;
   logic        SET_LOAD;
   logic        ERR;

   modport master (
      output KEY_Value, Value_en,
      input  ENTRY_ACTIVE, ENTRY_DIGITS, DIGIT_CNT, SET_HOUR, SET_MIN, SET_SEC, SET_LOAD, ERR
   );

   modport slave (
      input  KEY_Value, Value_en,
      output ENTRY_ACTIVE, ENTRY_DIGITS, DIGIT_CNT, SET_HOUR, SET_MIN, SET_SEC, SET_LOAD, ERR
   );
endinterface

// File: rtl/key_time_entry_bcd_pair_to_bin.sv
// Two BCD digits to binary (10*tens+units) with an over-limit flag against max_val.
module bcd_pair_to_bin (
   input  logic [3:0] tens,
   input  logic [3:0] units,
   input  logic [6:0] max_val,
   output logic [6:0] bin,
   output logic       over
);
   logic [7:0] full;

   // 8-bit intermediate so a stray blank nibble can never alias below max_val
   assign full = {4'd0, tens} * 8'd10 + {4'd0, units};
   assign bin  = full[6:0];
   assign over = full > {1'b0, max_val};
endmodule

// File: rtl/key_time_entry.sv
// Assembles a 6-digit HHMMSS entry from keypad strobes, validates it and pulses a load to the clock.
// Optional idle auto-cancel is built when ENTRY_TIMEOUT_EN is defined.
module key_time_entry
   import key_pkg::*;
#(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd270000000
) (
   input logic             CLK,
   input logic             nRST,
   key_time_entry_if.slave kif
);
   state_t          state, state_nxt;
   logic [5:0][3:0] digits;
   logic [2:0]      cnt;
   logic [4:0]      set_hour;
   logic [5:0]      set_min, set_sec;
   logic            set_load, err, entry_active;

   logic [3:0] key;
   logic       k_digit, k_start, k_bksp, k_cancel, k_commit, timeout;

   assign key      = kif.KEY_Value;
   assign k_digit  = kif.Value_en && is_digit(key);
   assign k_start  = kif.Value_en && (key == KEY_START);
   assign k_bksp   = kif.Value_en && (key == KEY_BKSP);
   assign k_cancel = kif.Value_en && (key == KEY_CANCEL);
   assign k_commit = kif.Value_en && (key == KEY_COMMIT);

   logic [6:0] hr_bin, mn_bin, sc_bin;
   logic       hr_over, mn_over, sc_over, entry_ok;
   logic       unused_bits;

   // Digits are only ever 0..9, so max 59 on a pair also enforces tens <= 5
   bcd_pair_to_bin u_hour (.tens(digits[5]), .units(digits[4]), .max_val(7'd23), .bin(hr_bin), .over(hr_over));
   bcd_pair_to_bin u_min  (.tens(digits[3]), .units(digits[2]), .max_val(7'd59), .bin(mn_bin), .over(mn_over));
   bcd_pair_to_bin u_sec  (.tens(digits[1]), .units(digits[0]), .max_val(7'd59), .bin(sc_bin), .over(sc_over));

   assign entry_ok    = !(hr_over || mn_over || sc_over);
   assign unused_bits = ^{hr_bin[6:5], mn_bin[6], sc_bin[6]};

`ifdef ENTRY_TIMEOUT_EN
   logic [31:0] tmo_cnt;
   logic        k_accept;

   assign k_accept = kif.Value_en && (key < 4'd14);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)                                    tmo_cnt <= '0;
      else if (state_nxt != ST_ENTRY || k_accept)   tmo_cnt <= '0;
      else                                          tmo_cnt <= tmo_cnt + 32'd1;
   end

   // A key on the expiry cycle takes precedence over the timeout
   assign timeout = (state == ST_ENTRY) && !k_accept && (tmo_cnt == TIMEOUT_CYCLES - 32'd1);
`else
   logic unused_tmo;
   assign unused_tmo = ^TIMEOUT_CYCLES;
   assign timeout    = 1'b0;
`endif

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (k_start) state_nxt = ST_ENTRY;
         ST_ENTRY: begin
            if (k_cancel || timeout)               state_nxt = ST_IDLE;
            else if (k_commit && cnt == 3'd6)      state_nxt = ST_CHECK;
         end
         ST_CHECK: state_nxt = entry_ok ? ST_IDLE : ST_ENTRY;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      entry_active = 1'b0;
      case (state)
         ST_ENTRY, ST_CHECK: entry_active = 1'b1;
         default:            entry_active = 1'b0;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         digits   <= DIGITS_BLANK;
         cnt      <= '0;
         set_hour <= '0;
         set_min  <= '0;
         set_sec  <= '0;
         set_load <= 1'b0;
         err      <= 1'b0;
      end else begin
         set_load <= 1'b0;
         err      <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (k_start) begin
                  digits <= DIGITS_BLANK;
                  cnt    <= '0;
               end
            end
            ST_ENTRY: begin
               if (k_start || k_cancel || timeout) begin
                  digits <= DIGITS_BLANK;
                  cnt    <= '0;
               end else if (k_digit && cnt < 3'd6) begin
                  digits[3'd5 - cnt] <= key;
                  cnt                <= cnt + 3'd1;
               end else if (k_bksp && cnt != 3'd0) begin
                  digits[3'd6 - cnt] <= BCD_BLANK;
                  cnt                <= cnt - 3'd1;
               end else if (k_commit && cnt != 3'd6) begin
                  err <= 1'b1;
               end
            end
            ST_CHECK: begin
               digits <= DIGITS_BLANK;
               cnt    <= '0;
               if (entry_ok) begin
                  set_hour <= hr_bin[4:0];
                  set_min  <= mn_bin[5:0];
                  set_sec  <= sc_bin[5:0];
                  set_load <= 1'b1;
               end else begin
                  err <= 1'b1;
               end
            end
            default: begin
               digits <= DIGITS_BLANK;
               cnt    <= '0;
            end
         endcase
      end
   end

   assign kif.ENTRY_ACTIVE = entry_active;
   assign kif.ENTRY_DIGITS = digits;
   assign kif.DIGIT_CNT    = cnt;
   assign kif.SET_HOUR     = set_hour;
   assign kif.SET_MIN      = set_min;
   assign kif.SET_SEC      = set_sec;
   assign kif.SET_LOAD     = set_load;
   assign kif.ERR          = err;
endmodule

// File: doc/key_time_entry.md
Name: key_time_entry

Overview:
- Consumer end of the keypad scanner's key-value interface: takes the one-cycle KEY_Value/Value_en strobes and assembles a 6-digit HHMMSS time-set entry for the clock.
- Provides BCD echo for the display, validates the entry and issues a one-cycle load pulse with binary hour/minute/second to the timekeeping counters.
- Sits between the keypad scanner and the clock core/display mux.

Parameters:
- TIMEOUT_CYCLES, 270000000, idle cycles in entry before auto-cancel (10 s at 27 MHz); counter 32 bits. Used only with ENTRY_TIMEOUT_EN.

Ports:
- CLK  input  1  system clock, all logic on rising edge
- nRST  input  1  asynchronous active-low reset
- KEY_Value  input  4  key code, valid only when Value_en=1
- Value_en  input  1  one-cycle strobe per key press
- ENTRY_ACTIVE  output  1  high while in entry mode
- ENTRY_DIGITS  output  24  six BCD nibbles, [23:20]=H tens … [3:0]=S units; unentered = 4'hF (blank)
- DIGIT_CNT  output  3  digits entered, 0..6
- SET_HOUR  output  5  binary hour 0..23, held until next load
- SET_MIN  output  6  binary minute 0..59, held
- SET_SEC  output  6  binary second 0..59, held
- SET_LOAD  output  1  one-cycle pulse, SET_* valid the same cycle
- ERR  output  1  one-cycle pulse on rejected commit

Behaviour:
- Reset (asynchronous, any state, including mid-entry): state=IDLE; ENTRY_ACTIVE=0; ENTRY_DIGITS=24'hFFFFFF; DIGIT_CNT=0; SET_HOUR/MIN/SET_SEC=0; SET_LOAD=0; ERR=0; timeout counter=0.
- Key codes: 0–9 digit; 10 (A) start entry; 11 (B) backspace; 12 (C) cancel; 13 (D) commit; 14, 15 ignored in every state.
- A key is sampled only on a cycle with Value_en=1. KEY_Value is ignored otherwise.
- FSM states: IDLE, ENTRY, CHECK.
- IDLE:
  - A → ENTRY next cycle; buffer all blank; DIGIT_CNT=0; ENTRY_ACTIVE=1.
  - All other keys are ignored.
- ENTRY:
  - Digit with DIGIT_CNT<6: written to nibble index DIGIT_CNT, counting from the MSB side; DIGIT_CNT+1. With DIGIT_CNT=6 the digit is ignored (no overwrite, no wrap).
  - B with DIGIT_CNT>0: nibble at DIGIT_CNT-1 → 4'hF; DIGIT_CNT-1. With DIGIT_CNT=0 it is a no-op.
  - C: → IDLE; buffer blank; DIGIT_CNT=0; ENTRY_ACTIVE=0.
  - A: restarts entry, clearing buffer and DIGIT_CNT.
  - D with DIGIT_CNT=6: → CHECK. D with DIGIT_CNT<6: ERR pulse next cycle, stay in ENTRY, buffer unchanged.
- CHECK (exactly one cycle):
  - Valid entry: hour tens ≤2 and hour ≤23; minute tens ≤5; second tens ≤5.
  - If valid: SET_HOUR = 10·Ht+Hu, SET_MIN = 10·Mt+Mu, SET_SEC = 10·St+Su, all registered; SET_LOAD=1 for one cycle; → IDLE; buffer blank; ENTRY_ACTIVE=0.
  - If invalid: ERR=1 for one cycle; → ENTRY; buffer blank; DIGIT_CNT=0.
  - Value_en arriving in CHECK is dropped.
- Latency: D strobe on cycle N → SET_LOAD or ERR asserted on cycle N+2. SET_* change only on cycles where SET_LOAD=1.
- ENTRY_ACTIVE is 1 exactly in ENTRY and CHECK.
- SET_LOAD and ERR are never high in the same cycle.

Optional Feature:
- Macro ENTRY_TIMEOUT_EN.
- Defined:
  - The counter runs in ENTRY and clears on every accepted Value_en and on leaving ENTRY.
  - On reaching TIMEOUT_CYCLES-1 the block behaves as if C were pressed: → IDLE, buffer blank, no ERR.
  - A key strobe on the same cycle as timeout wins; the counter clears.
- Undefined: no counter exists; entry persists indefinitely.

Decomposition:
- Shared package key_pkg holds:
  - Key code constants KEY_START=10, KEY_BKSP=11, KEY_CANCEL=12, KEY_COMMIT=13.
  - BCD_BLANK=4'hF.
  - FSM state encodings (one-hot, 3 bits).
- One sub-module, bcd_pair_to_bin: two BCD nibbles in → 7-bit binary out (10·tens+units), plus an over-limit flag against an input max. Instantiated three times.

Test Plan:
- Reset mid-entry: press A, 3, then assert nRST=0 → all outputs at reset values; ENTRY_DIGITS=FFFFFF immediately, without waiting for a clock edge.
- Valid commit: keys A,2,3,5,9,5,9,D → ENTRY_DIGITS=235959 before D; SET_LOAD at D+2; SET_HOUR=23, SET_MIN=59, SET_SEC=59; ERR=0.
- Invalid commit: keys A,2,4,0,0,0,0,D → ERR pulse at D+2; SET_* unchanged; ENTRY_ACTIVE=1; DIGIT_CNT=0.
- Short commit and overflow:
  - A,1,2,D → ERR; buffer still 12FFFF.
  - Then 3,4,5,6,7 → buffer 123456, 7 ignored, DIGIT_CNT=6.
- Backspace/cancel:
  - A,1,B,B → DIGIT_CNT=0, buffer FFFFFF.
  - Then C → IDLE, ENTRY_ACTIVE=0.
  - Keys 14/15 at any point → no change.
- ENTRY_TIMEOUT_EN with TIMEOUT_CYCLES=16: A,1, then idle 16 cycles → ENTRY_ACTIVE=0, no ERR, no SET_LOAD. Without the macro, same stimulus → still ENTRY.
